alu_wide_sequencer: RTL and testbench
=====================================

Name: alu_wide_sequencer

Overview:
Multi-precision arithmetic sequencer that sits directly upstream of the 8-bit ALU and drives its A/B/FuncOp/IFlags inputs. It accepts wide operands (Words x DataWidth bits), feeds the ALU one word per cycle from LSW to MSW, and chains the carry through IFlags. It collects the ALU's Y and OFlags outputs into a wide result and one aggregate V,N,C,Z flag set.

Parameters:
DataWidth, 8, ALU word width in bits
Words, 4, number of ALU words per operand; operand width = Words*DataWidth
FlagBits, 4, flag vector width; order is {V,N,C,Z}, bits 3..0

Ports:
Clk  in  1  clock; all state updates on the rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  request; sampled only in IDLE or DONE
Op  in  3  operation: 0 Add, 1 Sub, 2 And, 3 Or, 4 Xor; 5-7 illegal
CIn  in  1  carry-in for Add; ignored by all other ops
A  in  Words*DataWidth  operand A; captured at Start
B  in  Words*DataWidth  operand B; captured at Start
AluA  out  DataWidth  to ALU A
AluB  out  DataWidth  to ALU B
AluFuncOp  out  4  to ALU FuncOp
AluIFlags  out  FlagBits  to ALU IFlags; only bit 1 (carry) is driven, all other bits are 0
AluY  in  DataWidth  from ALU Y
AluOFlags  in  FlagBits  from ALU OFlags
Y  out  Words*DataWidth  wide result
Flags  out  FlagBits  aggregate {V,N,C,Z}
Busy  out  1  high while the sequence is running
Done  out  1  one-cycle pulse; Y and Flags are valid from this cycle

Behaviour:
- Reset: state IDLE; Y=0, Flags=0, Busy=0, Done=0; AluA, AluB, AluFuncOp and AluIFlags all 0. Reset overrides everything, including mid-sequence.
- FSM states: IDLE, RUN, DONE.
  - IDLE: Start=1 latches A, B, Op and CIn; sets idx=0; goes to RUN.
  - RUN: processes word idx each cycle. At idx=Words-1 it goes to DONE; otherwise idx increments.
  - DONE: Done=1 for this cycle. Start=1 here is accepted exactly as in IDLE (back-to-back). Otherwise goes to IDLE.
- Start while in RUN is ignored. Operand inputs are don't-care after the capture cycle.
- Latency: Start sampled in cycle 0; words 0..Words-1 processed in cycles 1..Words; Done in cycle Words+1. With the default Words=4, Done comes 5 cycles after Start.
- Busy=1 in RUN only.
- ALU drive in RUN (ALU is combinational; capture happens at the same clock edge):
  - AluA = captured A word idx.
  - Add: AluB = B word idx; AluFuncOp = 0 (Add_OP); carry-in = CIn at idx 0, then the chained carry.
  - Sub: AluB = ~(B word idx); AluFuncOp = 0 (Add_OP, not Sub_OP, because Sub_OP ignores carry); carry-in = 1 at idx 0, then the chained carry.
  - Sub carry meaning: final C=1 means no borrow.
  - And/Or/Xor: AluB = B word idx; AluFuncOp = 2/3/4; carry-in = 0.
  - Illegal op: AluFuncOp = 0 with AluA = AluB = 0 and carry-in = 0. Result is Y=0, Flags=4'b0001.
- Per-word capture in RUN:
  - Y word idx <= AluY.
  - Chained carry <= AluOFlags[1].
  - Zero accumulator: cleared to 1 at Start; ANDed with AluOFlags[0] each word.
- Aggregate flags, loaded at the last word and held:
  - Z = zero accumulator, including the last word's Z.
  - N = AluOFlags[2] of the MSW.
  - C = AluOFlags[1] of the MSW for Add/Sub; 0 for logic ops.
  - V = AluOFlags[3] of the MSW for Add/Sub; 0 for logic ops.
- Y and Flags hold their values from DONE until the next Start's first RUN cycle. Intermediate Y words are visible during RUN and are not valid until Done.
- Outside RUN, the ALU drive outputs return to 0.
- Words=1 is legal: single-cycle RUN; Done in cycle 2.

Test Plan:
Add A=0x000000FF, B=0x00000001, CIn=0 -> Y=0x00000100, Flags=4'b0000, Done exactly cycle 5, Busy high cycles 1-4.
Add A=0xFFFFFFFF, B=0x00000001, CIn=0 -> Y=0x00000000, Flags=4'b0011 (C,Z); repeat with B=0, CIn=1 -> same result.
Sub A=0x00000000, B=0x00000001 -> Y=0xFFFFFFFF, Flags=4'b0100 (N; C=0 borrow); Sub 5-5 -> Y=0, Flags=4'b0011.
Add A=0x7FFFFFFF, B=0x00000001 -> Y=0x80000000, Flags=4'b1100 (V,N); monitor AluFuncOp=0, AluIFlags=0/2 per word.
Xor A=B=0xA5A5A5A5 -> Y=0, Flags=4'b0001; Start pulsed in cycle 2 ignored; Start in DONE cycle with Or 0xF0,0x0F -> Y=0x000000FF, Done in cycle 10.
Reset asserted in cycle 3 of an Add -> next cycle IDLE, Y=0, Flags=0, Busy=0, Done=0, ALU drives 0; new Start completes normally; Op=6 -> Y=0, Flags=4'b0001.

Source files
------------

// File: rtl/alu_wide_sequencer_if.sv
// Request/result bus of the wide sequencer plus its drive/return link to the 8-bit ALU.
// slave = sequencer side, master = requester and ALU side.
interface alu_wide_sequencer_if #(
    parameter int DataWidth = 8,
    parameter int Words     = 4,
    parameter int FlagBits  = 4
);
    logic                         start;
    logic [2:0]                   op;
    logic                         cin;
    logic [Words*DataWidth-1:0]   a;
    logic [Words*DataWidth-1:0]   b;
    logic [Words*DataWidth-1:0]   y;
    logic [FlagBits-1:0]          flags;
    logic                         busy;
    logic                         done;
    logic [DataWidth-1:0]         alu_a;
    logic [DataWidth-1:0]         alu_b;
    logic [3:0]                   alu_func_op;
    logic [FlagBits-1:0]          alu_iflags;
    logic [DataWidth-1:0]         alu_y;
    logic [FlagBits-1:0]          alu_oflags;

    modport slave (
        input  start, op, cin, a, b, alu_y, alu_oflags,
        output y, flags, busy, done, alu_a, alu_b, alu_func_op, alu_iflags
    );

    modport master (
        output start, op, cin, a, b, alu_y, alu_oflags,
        input  y, flags, busy, done, alu_a, alu_b, alu_func_op, alu_iflags
    );
endinterface

// File: rtl/alu_wide_sequencer.sv
// Multi-precision sequencer: feeds the combinational 8-bit ALU one word per cycle, LSW first,
// chaining carry through IFlags[1] and folding per-word flags into one {V,N,C,Z} result.
module alu_wide_sequencer #(
    parameter int DataWidth = 8,
    parameter int Words     = 4,
    parameter int FlagBits  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    alu_wide_sequencer_if.slave   bus
);
    localparam int IdxW = (Words > 1) ? $clog2(Words) : 1;
    localparam int OpW  = Words * DataWidth;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q;
    logic [IdxW-1:0]      idx_q;
    logic [OpW-1:0]       a_q;
    logic [OpW-1:0]       b_q;
    logic [2:0]           op_q;
    logic                 cin_q;
    logic                 carry_q;
    logic                 zacc_q;
    logic [OpW-1:0]       y_q;
    logic [FlagBits-1:0]  flags_q;

    logic [DataWidth-1:0] a_word;
    logic [DataWidth-1:0] b_word;
    logic [DataWidth-1:0] alu_a_c;
    logic [DataWidth-1:0] alu_b_c;
    logic [3:0]           alu_func_c;
    logic [FlagBits-1:0]  alu_iflags_c;
    logic                 alu_cin_c;
    logic                 is_arith;
    logic                 last_word;
    logic [FlagBits-1:0]  final_flags;

    assign a_word    = a_q[int'(idx_q)*DataWidth +: DataWidth];
    assign b_word    = b_q[int'(idx_q)*DataWidth +: DataWidth];
    assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign last_word = (idx_q == IdxW'(Words - 1));

    // Subtract runs on Add_OP as A + ~B + 1 so the borrow can ride the carry chain.
    always_comb begin
        alu_a_c   = '0;
        alu_b_c   = '0;
        alu_func_c = 4'd0;
        alu_cin_c = 1'b0;
        if (state_q == RUN) begin
            case (op_q)
                OP_ADD: begin
                    alu_a_c   = a_word;
                    alu_b_c   = b_word;
                    alu_cin_c = (idx_q == '0) ? cin_q : carry_q;
                end
                OP_SUB: begin
                    alu_a_c   = a_word;
                    alu_b_c   = ~b_word;
                    alu_cin_c = (idx_q == '0) ? 1'b1 : carry_q;
                end
                OP_AND, OP_OR, OP_XOR: begin
                    alu_a_c    = a_word;
                    alu_b_c    = b_word;
                    alu_func_c = {1'b0, op_q};
                end
                default: ;
            endcase
        end
        alu_iflags_c    = '0;
        alu_iflags_c[1] = alu_cin_c;
    end

    always_comb begin
        final_flags    = '0;
        final_flags[3] = is_arith & bus.alu_oflags[3];
        final_flags[2] = bus.alu_oflags[2];
        final_flags[1] = is_arith & bus.alu_oflags[1];
        final_flags[0] = zacc_q & bus.alu_oflags[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            y_q     <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= bus.op;
                        cin_q   <= bus.cin;
                        idx_q   <= '0;
                        zacc_q  <= 1'b1;
                        carry_q <= 1'b0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    y_q[int'(idx_q)*DataWidth +: DataWidth] <= bus.alu_y;
                    carry_q <= bus.alu_oflags[1];
                    zacc_q  <= zacc_q & bus.alu_oflags[0];
                    if (last_word) begin
                        flags_q <= final_flags;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_a       = alu_a_c;
    assign bus.alu_b       = alu_b_c;
    assign bus.alu_func_op = alu_func_c;
    assign bus.alu_iflags  = alu_iflags_c;
    assign bus.y           = y_q;
    assign bus.flags       = flags_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer with a behavioural 8-bit ALU closing the loop.
module tb_alu_wide_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_wide_sequencer_if #(.DataWidth(8), .Words(4), .FlagBits(4)) bus ();

    alu_wide_sequencer #(.DataWidth(8), .Words(4), .FlagBits(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: FuncOp 0 add with carry-in IFlags[1], 2/3/4 and/or/xor.
    logic [8:0] alu_sum;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_v;
    always_comb begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_iflags[1]};
        alu_res = 8'd0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.alu_func_op)
            4'd0: begin
                alu_res = alu_sum[7:0];
                alu_c   = alu_sum[8];
                alu_v   = (bus.alu_a[7] == bus.alu_b[7]) && (alu_res[7] != bus.alu_a[7]);
            end
            4'd2: alu_res = bus.alu_a & bus.alu_b;
            4'd3: alu_res = bus.alu_a | bus.alu_b;
            4'd4: alu_res = bus.alu_a ^ bus.alu_b;
            default: alu_res = 8'd0;
        endcase
        bus.alu_y      = alu_res;
        bus.alu_oflags = {alu_v, alu_res[7], alu_c, (alu_res == 8'd0)};
    end

    // Starts one operation (optionally in the DONE cycle of the previous one) and
    // waits, bounded, for Done. Cycle numbers count from the Start-sampling edge.
    task automatic run_op(input logic b2b, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cin, output int done_cyc,
                          output logic [31:0] busy_mask, output logic [31:0] y,
                          output logic [3:0] f);
        if (!b2b) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'd4; bus.a = ~a; bus.b = ~b; bus.cin = ~cin;
        done_cyc = -1; busy_mask = '0; y = '0; f = '0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.busy) busy_mask[c] = 1'b1;
            if (bus.done) begin
                done_cyc = c; y = bus.y; f = bus.flags;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.y, bus.flags} !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b y=%h flags=%b exp all 0",
                     bus.busy, bus.done, bus.y, bus.flags);
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_func_op, bus.alu_iflags} !== 24'd0) begin
            failures++;
            $display("FAIL reset_alu_drive got a=%h b=%h fop=%h if=%b exp 0",
                     bus.alu_a, bus.alu_b, bus.alu_func_op, bus.alu_iflags);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_basic();
        int d; logic [31:0] bm, y; logic [3:0] f;
        run_op(1'b0, 3'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0, d, bm, y, f);
        checks++;
        if (d !== 5) begin failures++; $display("FAIL add_basic_done_cycle got=%0d exp=5", d); end
        checks++;
        if (bm !== 32'h0000_001E) begin failures++; $display("FAIL add_basic_busy_cycles got=%h exp=0000001e", bm); end
        checks++;
        if (y !== 32'h0000_0100) begin failures++; $display("FAIL add_basic_y got=%h exp=00000100", y); end
        checks++;
        if (f !== 4'b0000) begin failures++; $display("FAIL add_basic_flags got=%b exp=0000", f); end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.y !== 32'h0000_0100) begin
            failures++;
            $display("FAIL add_basic_after_done got done=%b y=%h exp done=0 y=00000100", bus.done, bus.y);
        end
    endtask

    task automatic test_add_carry();
        int d; logic [31:0] bm, y; logic [3:0] f;
        run_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, d, bm, y, f);
        checks++;
        if (d !== 5 || y !== 32'h0 || f !== 4'b0011) begin
            failures++;
            $display("FAIL add_wrap got d=%0d y=%h f=%b exp d=5 y=00000000 f=0011", d, y, f);
        end
        run_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, d, bm, y, f);
        checks++;
        if (d !== 5 || y !== 32'h0 || f !== 4'b0011) begin
            failures++;
            $display("FAIL add_cin_wrap got d=%0d y=%h f=%b exp d=5 y=00000000 f=0011", d, y, f);
        end
    endtask

    task automatic test_sub();
        int d; logic [31:0] bm, y; logic [3:0] f;
        run_op(1'b0, 3'd1, 32'h0000_0000, 32'h0000_0001, 1'b0, d, bm, y, f);
        checks++;
        if (d !== 5 || y !== 32'hFFFF_FFFF || f !== 4'b0100) begin
            failures++;
            $display("FAIL sub_borrow got d=%0d y=%h f=%b exp d=5 y=ffffffff f=0100", d, y, f);
        end
        run_op(1'b0, 3'd1, 32'h0000_0005, 32'h0000_0005, 1'b0, d, bm, y, f);
        checks++;
        if (d !== 5 || y !== 32'h0 || f !== 4'b0011) begin
            failures++;
            $display("FAIL sub_equal got d=%0d y=%h f=%b exp d=5 y=00000000 f=0011", d, y, f);
        end
    endtask

    task automatic test_add_overflow();
        logic [3:0] exp_if [4];
        logic [7:0] exp_a  [4];
        exp_if = '{4'd0, 4'd2, 4'd2, 4'd2};
        exp_a  = '{8'hFF, 8'hFF, 8'hFF, 8'h7F};
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h7FFF_FFFF; bus.b = 32'h0000_0001; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = 32'h0; bus.b = 32'h0;
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.alu_func_op !== 4'd0 || bus.alu_iflags !== exp_if[w]
                || bus.alu_a !== exp_a[w]) begin
                failures++;
                $display("FAIL ovf_drive_w%0d got busy=%b fop=%h if=%h a=%h exp busy=1 fop=0 if=%h a=%h",
                         w, bus.busy, bus.alu_func_op, bus.alu_iflags, bus.alu_a, exp_if[w], exp_a[w]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.y !== 32'h8000_0000 || bus.flags !== 4'b1100) begin
            failures++;
            $display("FAIL ovf_result got done=%b y=%h f=%b exp done=1 y=80000000 f=1100",
                     bus.done, bus.y, bus.flags);
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_func_op, bus.alu_iflags} !== 24'd0) begin
            failures++;
            $display("FAIL ovf_done_drive got a=%h b=%h fop=%h if=%h exp 0",
                     bus.alu_a, bus.alu_b, bus.alu_func_op, bus.alu_iflags);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; int d1; int d2; logic [31:0] y1; logic [3:0] f1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hA5A5_A5A5; bus.b = 32'hA5A5_A5A5; bus.cin = 1'b0;
        @(posedge clk); #1;
        cyc = 1; d1 = -1; d2 = -1; y1 = '0; f1 = '0;
        bus.start = 1'b0;
        while (cyc <= 25 && d2 < 0) begin
            if (cyc == 2) begin
                bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'hFFFF_FFFF; bus.b = 32'h0;
            end else if (cyc == 3) begin
                bus.start = 1'b0;
            end
            if (bus.done && d1 < 0) begin
                d1 = cyc; y1 = bus.y; f1 = bus.flags;
                bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'h0000_00F0; bus.b = 32'h0000_000F;
            end else if (bus.done) begin
                d2 = cyc;
            end else if (d1 >= 0) begin
                bus.start = 1'b0;
            end
            if (d2 < 0) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checks++;
        if (d1 !== 5 || y1 !== 32'h0 || f1 !== 4'b0001) begin
            failures++;
            $display("FAIL xor_ignore_start got d=%0d y=%h f=%b exp d=5 y=00000000 f=0001", d1, y1, f1);
        end
        checks++;
        if (d2 !== 10 || bus.y !== 32'h0000_00FF || bus.flags !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_or got d=%0d y=%h f=%b exp d=10 y=000000ff f=0000", d2, bus.y, bus.flags);
        end
    endtask

    task automatic test_reset_mid();
        int d; logic [31:0] bm, y; logic [3:0] f;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.busy, bus.done, bus.y, bus.flags} !== 38'd0
            || {bus.alu_a, bus.alu_b, bus.alu_func_op, bus.alu_iflags} !== 24'd0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b y=%h f=%b a=%h b=%h fop=%h if=%h exp all 0",
                     bus.busy, bus.done, bus.y, bus.flags, bus.alu_a, bus.alu_b,
                     bus.alu_func_op, bus.alu_iflags);
        end
        rst = 1'b0;
        run_op(1'b0, 3'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, d, bm, y, f);
        checks++;
        if (d !== 5 || y !== 32'h2345_6789 || f !== 4'b0000) begin
            failures++;
            $display("FAIL post_reset_add got d=%0d y=%h f=%b exp d=5 y=23456789 f=0000", d, y, f);
        end
        run_op(1'b0, 3'd6, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, d, bm, y, f);
        checks++;
        if (d !== 5 || y !== 32'h0 || f !== 4'b0001) begin
            failures++;
            $display("FAIL illegal_op got d=%0d y=%h f=%b exp d=5 y=00000000 f=0001", d, y, f);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_add_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
